// File: rtl/mul_pkg.sv
// Shared types for the multiplier writeback stage: op encoding, FIFO entry, default depth.
package mul_pkg;

    typedef enum logic [1:0] {
        OP_MUL  = 2'b00,
        OP_MULH = 2'b01,
        OP_MAC  = 2'b10,
        OP_ACCH = 2'b11
    } mul_op_e;

    typedef struct packed {
        logic        carry;
        logic [31:0] data;
    } wb_entry_t;

    localparam int MULWB_DEPTH = 2;

endpackage

// File: rtl/mulwb_fifo.sv
// Circular result buffer; when empty the output holds the most recently popped entry.
module mulwb_fifo
    import mul_pkg::*;
#(
    parameter int DEPTH = MULWB_DEPTH
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push_i,
    input  logic      pop_i,
    input  wb_entry_t wdata_i,
    output logic      full_o,
    output logic      empty_o,
    output wb_entry_t rdata_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    wb_entry_t         mem_q [DEPTH];
    wb_entry_t         last_q;
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       cnt_q, cnt_d;

    assign full_o  = (cnt_q == FULL_CNT);
    assign empty_o = (cnt_q == '0);
    assign rdata_o = empty_o ? last_q : mem_q[rd_ptr_q];

    always_comb begin
        cnt_d = cnt_q;
        if (push_i && !pop_i)
            cnt_d = cnt_q + 1'b1;
        else if (pop_i && !push_i)
            cnt_d = cnt_q - 1'b1;
    end

    // Power-of-two depth: pointer increment wraps DEPTH-1 -> 0 naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            last_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            cnt_q <= cnt_d;
            if (push_i) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                last_q   <= mem_q[rd_ptr_q];
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mul_writeback.sv
// Multiplier result stage: op decode, optional accumulator (MULWB_ACC_EN), result FIFO.
module mul_writeback
    import mul_pkg::*;
#(
    parameter int DEPTH = MULWB_DEPTH
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] in_prod,
    input  logic [1:0]  in_op,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_carry
);

    logic      full, empty, push, pop;
    wb_entry_t entry, head;
    mul_op_e   op;

    assign op        = mul_op_e'(in_op);
    assign in_ready  = !full;
    assign out_valid = !empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out_data  = head.data;
    assign out_carry = head.carry;

`ifdef MULWB_ACC_EN
    logic [63:0] acc_q, acc_d;
    logic [64:0] sum;

    assign sum = {1'b0, acc_q} + {1'b0, in_prod};

    always_comb begin
        entry = '0;
        acc_d = acc_q;
        unique case (op)
            OP_MUL:  entry.data = in_prod[31:0];
            OP_MULH: entry.data = in_prod[63:32];
            OP_MAC: begin
                entry.carry = sum[64];
                entry.data  = sum[31:0];
                acc_d       = sum[63:0];
            end
            OP_ACCH: begin
                entry.data = acc_q[63:32];
                acc_d      = '0;
            end
            default: ;
        endcase
    end

    // Accumulator only moves on an accepted push; a stalled MAC leaves it intact.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            acc_q <= '0;
        else if (push)
            acc_q <= acc_d;
    end
`else
    // Without the accumulator MAC folds to MUL and ACCH to MULH.
    always_comb begin
        entry      = '0;
        entry.data = in_op[0] ? in_prod[63:32] : in_prod[31:0];
    end
`endif

    mulwb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (entry),
        .full_o  (full),
        .empty_o (empty),
        .rdata_o (head)
    );

endmodule

// File: tb/tb_mul_writeback.sv
// Self-checking bench for mul_writeback: directed cases plus random traffic vs a queue model.
module tb_mul_writeback;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_prod = '0;
    logic [1:0]  in_op = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_data;
    logic        out_carry;

    int checks = 0;
    int failures = 0;

    // Model state: queue of {carry, data}, accumulator, last popped entry.
    logic [32:0] mq[$];
    logic [63:0] macc = '0;
    logic [32:0] mlast = '0;

    mul_writeback #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_prod   (in_prod),
        .in_op     (in_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_carry (out_carry)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [32:0] model_push(input logic [1:0] op, input logic [63:0] p);
        logic [64:0] s;
`ifdef MULWB_ACC_EN
        case (op)
            2'b00: return {1'b0, p[31:0]};
            2'b01: return {1'b0, p[63:32]};
            2'b10: begin
                s    = {1'b0, macc} + {1'b0, p};
                macc = s[63:0];
                return {s[64], s[31:0]};
            end
            default: begin
                s    = {1'b0, macc};
                macc = 64'd0;
                return {1'b0, s[63:32]};
            end
        endcase
`else
        s = {1'b0, p};
        return {1'b0, op[0] ? s[63:32] : s[31:0]};
`endif
    endfunction

    task automatic model_reset();
        mq.delete();
        macc  = '0;
        mlast = '0;
    endtask

    // One clock: drive inputs, check outputs at negedge, then advance the model past the posedge.
    task automatic cyc(input logic v, input logic [1:0] op, input logic [63:0] p, input logic rdy);
        logic push, pop;
        in_valid  = v;
        in_op     = op;
        in_prod   = p;
        out_ready = rdy;
        @(negedge clk);
        chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
        chk("in_ready", 64'(in_ready), 64'(mq.size() < DEPTH));
        if (mq.size() != 0) begin
            chk("out_data", 64'(out_data), 64'(mq[0][31:0]));
            chk("out_carry", 64'(out_carry), 64'(mq[0][32]));
        end else begin
            chk("hold_data", 64'(out_data), 64'(mlast[31:0]));
        end
        push = v && (mq.size() < DEPTH);
        pop  = rdy && (mq.size() != 0);
        @(posedge clk);
        #1;
        if (pop) mlast = mq.pop_front();
        if (push) mq.push_back(model_push(op, p));
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_carry", 64'(out_carry), 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        #12;
        do_reset();

        // MUL / MULH basics
        cyc(1, 2'b00, 64'h00000002_00000003, 1);
        cyc(1, 2'b01, 64'h00000002_00000003, 1);
        cyc(0, 2'b00, 64'd0, 1);
        cyc(0, 2'b00, 64'd0, 1);

        // MAC carry-out, ACCH clears, then prove acc was cleared
        cyc(1, 2'b10, 64'hFFFFFFFF_FFFFFFFF, 1);
        cyc(1, 2'b10, 64'h00000000_00000002, 1);
        cyc(1, 2'b11, 64'h12345678_9ABCDEF0, 1);
        cyc(1, 2'b10, 64'h00000001_00000000, 1);
        cyc(1, 2'b11, 64'd0, 1);
        cyc(0, 2'b00, 64'd0, 1);
        cyc(0, 2'b00, 64'd0, 1);

        // Stall: fill, refused MAC must not touch acc, then drain in order
        cyc(1, 2'b00, 64'h0000000A_00000011, 0);
        cyc(1, 2'b00, 64'h0000000B_00000022, 0);
        chk("full_ready", 64'(in_ready), 64'd0);
        cyc(1, 2'b10, 64'h00000777_00000055, 0);
        cyc(0, 2'b00, 64'd0, 1);
        cyc(0, 2'b00, 64'd0, 1);
        cyc(1, 2'b11, 64'd0, 1);
        cyc(0, 2'b00, 64'd0, 1);
        cyc(0, 2'b00, 64'd0, 1);

        // Streaming: 8 results, pointers wrap several times
        for (int i = 0; i < 8; i++)
            cyc(1, 2'(i % 3), {32'(i + 100), 32'(i)}, 1);
        cyc(0, 2'b00, 64'd0, 1);
        cyc(0, 2'b00, 64'd0, 1);

        // Reset with 2 entries held and a non-zero accumulator
        cyc(1, 2'b10, 64'h00000009_00000009, 0);
        cyc(1, 2'b00, 64'h00000001_00000001, 0);
        do_reset();
        cyc(1, 2'b11, 64'd0, 1);
        cyc(1, 2'b10, 64'h00000000_00000004, 1);
        cyc(0, 2'b00, 64'd0, 1);
        cyc(0, 2'b00, 64'd0, 1);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            logic [63:0] p;
            p = {32'($urandom), 32'($urandom)};
            if ($urandom_range(0, 7) == 0) p = 64'hFFFFFFFF_FFFFFFFF - 64'($urandom_range(0, 3));
            cyc(1'($urandom_range(0, 3) != 0), 2'($urandom), p, 1'($urandom_range(0, 2) != 0));
            if (i == 300) do_reset();
        end
        cyc(0, 2'b00, 64'd0, 1);
        cyc(0, 2'b00, 64'd0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
